// File: rtl/wb_slave_pkg.sv
// Shared types and default sizes for the Wishbone slave front end.
// Imported by the interface, the controller and its bench.
package wb_slave_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_MEM_DEPTH  = 256;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RD_WAIT,
        ACK,
        ERR
    } wb_state_t;

endpackage

// File: rtl/wb_slave_ctrl_if.sv
// Wishbone classic-cycle bus bundle between a master and this slave.
// The slave modport sees the request side as inputs.
interface wb_slave_ctrl_if
    import wb_slave_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

    logic                  wb_cyc_i;
    logic                  wb_stb_i;
    logic                  wb_we_i;
    logic [ADDR_WIDTH-1:0] wb_adr_i;
    logic [DATA_WIDTH-1:0] wb_dat_i;
    logic [DATA_WIDTH-1:0] wb_dat_o;
    logic                  wb_ack_o;
    logic                  wb_err_o;

    modport master (
        output wb_cyc_i,
        output wb_stb_i,
        output wb_we_i,
        output wb_adr_i,
        output wb_dat_i,
        input  wb_dat_o,
        input  wb_ack_o,
        input  wb_err_o
    );

    modport slave (
        input  wb_cyc_i,
        input  wb_stb_i,
        input  wb_we_i,
        input  wb_adr_i,
        input  wb_dat_i,
        output wb_dat_o,
        output wb_ack_o,
        output wb_err_o
    );

endinterface

// File: rtl/wb_slave_ctrl.sv
// Wishbone classic slave: turns single bus cycles into one-cycle
// memory enables with registered address/data; all outputs registered.
module wb_slave_ctrl
    import wb_slave_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MEM_DEPTH  = DEF_MEM_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    wb_slave_ctrl_if.slave        wb,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata
);

    // One extra bit so a depth of exactly 2**ADDR_WIDTH still fits.
    localparam logic [ADDR_WIDTH:0] DEPTH = MEM_DEPTH[ADDR_WIDTH:0];

    wb_state_t state;
    logic      request;
    logic      out_of_range;

    assign request      = wb.wb_cyc_i & wb.wb_stb_i;
    assign out_of_range = {1'b0, wb.wb_adr_i} >= DEPTH;

    // Transaction FSM; enables and terminations default to a one-cycle pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            addr        <= '0;
            wdata       <= '0;
            wr_en       <= 1'b0;
            rd_en       <= 1'b0;
            wb.wb_dat_o <= '0;
            wb.wb_ack_o <= 1'b0;
            wb.wb_err_o <= 1'b0;
        end else begin
            wr_en       <= 1'b0;
            rd_en       <= 1'b0;
            wb.wb_ack_o <= 1'b0;
            wb.wb_err_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (request) begin
                        if (out_of_range) begin
                            wb.wb_err_o <= 1'b1;
                            state       <= ERR;
                        end else begin
                            addr <= wb.wb_adr_i;
                            if (wb.wb_we_i) begin
                                wdata <= wb.wb_dat_i;
                                wr_en <= 1'b1;
                                state <= WR;
                            end else begin
                                rd_en <= 1'b1;
                                state <= RD;
                            end
                        end
                    end
                end
                WR: begin
                    if (wb.wb_cyc_i) begin
                        wb.wb_ack_o <= 1'b1;
                        state       <= ACK;
                    end else begin
                        state <= IDLE;
                    end
                end
                RD: begin
                    state <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (wb.wb_cyc_i) begin
                        wb.wb_dat_o <= rdata;
                        wb.wb_ack_o <= 1'b1;
                        state       <= ACK;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACK, ERR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_slave_ctrl.sv
// Directed bench for wb_slave_ctrl with a small registered memory model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_wb_slave_ctrl;
    import wb_slave_pkg::*;

    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 128;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] addr;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata = '0;
    logic [DW-1:0] mem [DEPTH];

    int n_cmp = 0;
    int n_bad = 0;
    int overlap_cnt = 0;
    int both_term_cnt = 0;
    int dbl_term_cnt = 0;
    int x_cnt = 0;
    logic prev_term = 1'b0;

    always #5 clk = ~clk;

    wb_slave_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    wb_slave_ctrl #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MEM_DEPTH (DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .wb   (bus.slave),
        .addr (addr),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .wdata(wdata),
        .rdata(rdata)
    );

    // Memory: write on wr_en, read data valid the cycle after rd_en.
    always @(posedge clk) begin
        if (wr_en) mem[addr[6:0]] <= wdata;
        if (rd_en) rdata <= mem[addr[6:0]];
    end

    // Protocol monitor for properties that must hold on every cycle.
    always @(negedge clk) begin
        if (reset) begin
            prev_term = 1'b0;
        end else begin
            if (wr_en && rd_en) overlap_cnt++;
            if (bus.wb_ack_o && bus.wb_err_o) both_term_cnt++;
            if (prev_term && (bus.wb_ack_o || bus.wb_err_o)) dbl_term_cnt++;
            if ((wr_en || rd_en) && $isunknown({addr, wdata})) x_cnt++;
            prev_term = bus.wb_ack_o | bus.wb_err_o;
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic req(input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = we;
        bus.wb_adr_i = a;
        bus.wb_dat_i = d;
    endtask

    task automatic idle();
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        req(1'b1, a, d);
        tick();
        check("wr_en c1", wr_en, 1);
        check("wr addr c1", addr, a);
        check("wdata c1", wdata, d);
        check("wr rd_en c1", rd_en, 0);
        check("wr ack c1", bus.wb_ack_o, 0);
        tick();
        check("wr ack c2", bus.wb_ack_o, 1);
        check("wr_en c2", wr_en, 0);
        idle();
        tick();
        check("wr ack c3", bus.wb_ack_o, 0);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        req(1'b0, a, '0);
        tick();
        check("rd_en c1", rd_en, 1);
        check("rd addr c1", addr, a);
        check("rd wr_en c1", wr_en, 0);
        tick();
        check("rd_en c2", rd_en, 0);
        check("rd ack c2", bus.wb_ack_o, 0);
        tick();
        check("rd ack c3", bus.wb_ack_o, 1);
        check("rd dat_o c3", bus.wb_dat_o, exp);
        idle();
        tick();
        check("rd ack c4", bus.wb_ack_o, 0);
    endtask

    task automatic do_err(input logic [AW-1:0] a);
        req(1'b1, a, '1);
        tick();
        check("err c1", bus.wb_err_o, 1);
        check("err wr_en c1", wr_en, 0);
        check("err rd_en c1", rd_en, 0);
        check("err ack c1", bus.wb_ack_o, 0);
        idle();
        tick();
        check("err c2", bus.wb_err_o, 0);
        check("err ack c2", bus.wb_ack_o, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " dat_o"}, bus.wb_dat_o, 0);
        check({tag, " ack"}, bus.wb_ack_o, 0);
        check({tag, " err"}, bus.wb_err_o, 0);
        check({tag, " addr"}, addr, 0);
        check({tag, " wr_en"}, wr_en, 0);
        check({tag, " rd_en"}, rd_en, 0);
        check({tag, " wdata"}, wdata, 0);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        bus.wb_adr_i = '0;
        bus.wb_dat_i = '0;
        repeat (2) tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // Basic write then read back.
        do_write(8'h10, 32'hDEADBEEF);
        do_read(8'h10, 32'hDEADBEEF);

        // Out-of-range accesses and the in-range boundary.
        do_err(8'hC8);
        do_err(8'h80);
        do_err(8'hFF);
        do_write(8'h7F, 32'h0000_7F7F);
        do_read(8'h7F, 32'h0000_7F7F);

        // Back-to-back: request held across ack, write then read.
        req(1'b1, 8'h01, 32'hA5A5_0001);
        tick();
        check("b2b wr_en c1", wr_en, 1);
        tick();
        check("b2b ack c2", bus.wb_ack_o, 1);
        bus.wb_we_i = 1'b0;
        tick();
        check("b2b idle ack", bus.wb_ack_o, 0);
        check("b2b idle rd_en", rd_en, 0);
        check("b2b idle wr_en", wr_en, 0);
        tick();
        check("b2b rd_en c1", rd_en, 1);
        bus.wb_stb_i = 1'b0;
        tick();
        tick();
        check("b2b rd ack", bus.wb_ack_o, 1);
        check("b2b rd dat_o", bus.wb_dat_o, 32'hA5A5_0001);
        idle();
        tick();

        // Abort a read in RD_WAIT: no ack, dat_o keeps its old value.
        do_write(8'h20, 32'h1234_5678);
        req(1'b0, 8'h20, '0);
        tick();
        check("abort rd_en", rd_en, 1);
        tick();
        idle();
        tick();
        check("abort ack", bus.wb_ack_o, 0);
        check("abort dat_o", bus.wb_dat_o, 32'hA5A5_0001);
        tick();
        check("abort ack late", bus.wb_ack_o, 0);
        do_read(8'h20, 32'h1234_5678);

        // Abort a write in WR: the write lands, no ack.
        req(1'b1, 8'h30, 32'h0000_0030);
        tick();
        check("wabort wr_en", wr_en, 1);
        idle();
        tick();
        check("wabort ack", bus.wb_ack_o, 0);
        tick();
        check("wabort ack late", bus.wb_ack_o, 0);
        do_read(8'h30, 32'h0000_0030);

        // Reset asserted while in WR.
        req(1'b1, 8'h40, 32'hCAFE_F00D);
        tick();
        check("rst wr_en", wr_en, 1);
        reset = 1'b1;
        tick();
        check_all_zero("midrst");
        reset = 1'b0;
        idle();
        tick();
        check("midrst ack after", bus.wb_ack_o, 0);
        check("midrst err after", bus.wb_err_o, 0);
        do_read(8'h10, 32'hDEADBEEF);

        check("enable overlap", overlap_cnt, 0);
        check("ack with err", both_term_cnt, 0);
        check("double termination", dbl_term_cnt, 0);
        check("x at enable", x_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
